// File: rtl/interval_timer.sv
// Interval timer for the traffic-light controller: holds the three programmable
// durations, divides the clock to one-second ticks and reports expiry/kick pulses.
module interval_timer #(
    parameter int CLK_HZ   = 50000000,
    parameter int DEF_BASE = 6,
    parameter int DEF_EXT  = 3,
    parameter int DEF_YEL  = 2
) (
    input  logic       clock,
    input  logic       reset_sync,
    input  logic       prog_sync,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    input  logic [1:0] interval,
    input  logic       start_timer,
    output logic       expired,
    output logic       one_hz_enable,
    output logic [3:0] seconds_left
);

    localparam int             DIV_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_HZ - 1);
    localparam logic [3:0]     DEF_BASE_V = 4'(DEF_BASE);
    localparam logic [3:0]     DEF_EXT_V  = 4'(DEF_EXT);
    localparam logic [3:0]     DEF_YEL_V  = 4'(DEF_YEL);

    typedef enum logic [1:0] {
        ST_KICK       = 2'b00,
        ST_WAIT_START = 2'b01,
        ST_RUNNING    = 2'b10,
        ST_EXPIRE     = 2'b11
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_divider;
    logic [3:0]       r_count;
    logic [3:0]       r_t_base;
    logic [3:0]       r_t_ext;
    logic [3:0]       r_t_yel;
    logic             r_expired;
    logic             r_one_hz;
    logic [3:0]       r_seconds_left;

    logic [3:0]       w_interval_value;
    logic [3:0]       w_count_dec;

    // A programmed zero means "restore the default" so a duration can never be zero.
    function automatic logic [3:0] f_load_value(input logic [3:0] value,
                                                input logic [3:0] def_value);
        logic [3:0] result;
        if (value == 4'd0) begin
            result = def_value;
        end else begin
            result = value;
        end
        return result;
    endfunction

    // Duration selected by the FSM's interval code; code 11 falls back to t_base.
    always_comb begin
        w_interval_value = r_t_base;
        case (interval)
            2'b00:   w_interval_value = r_t_base;
            2'b01:   w_interval_value = r_t_ext;
            2'b10:   w_interval_value = r_t_yel;
            default: w_interval_value = r_t_base;
        endcase
    end

    assign w_count_dec = r_count - 4'd1;

    // Duration registers: written on every edge while the program strobe is high.
    always_ff @(posedge clock) begin
        if (reset_sync) begin
            r_t_base <= DEF_BASE_V;
            r_t_ext  <= DEF_EXT_V;
            r_t_yel  <= DEF_YEL_V;
        end else if (prog_sync) begin
            case (time_param_sel)
                2'b00:   r_t_base <= f_load_value(time_value, DEF_BASE_V);
                2'b01:   r_t_ext  <= f_load_value(time_value, DEF_EXT_V);
                2'b10:   r_t_yel  <= f_load_value(time_value, DEF_YEL_V);
                default: r_t_base <= r_t_base;
            endcase
        end else begin
            r_t_base <= r_t_base;
        end
    end

    // Timer FSM with registered outputs; programming aborts any run and re-arms the kick.
    always_ff @(posedge clock) begin
        if (reset_sync) begin
            r_state        <= ST_KICK;
            r_divider      <= '0;
            r_count        <= 4'd0;
            r_expired      <= 1'b0;
            r_one_hz       <= 1'b0;
            r_seconds_left <= 4'd0;
        end else if (prog_sync) begin
            r_state        <= ST_KICK;
            r_divider      <= '0;
            r_count        <= 4'd0;
            r_expired      <= 1'b0;
            r_one_hz       <= 1'b0;
            r_seconds_left <= 4'd0;
        end else begin
            case (r_state)
                ST_KICK: begin
                    r_state        <= ST_WAIT_START;
                    r_divider      <= '0;
                    r_count        <= 4'd0;
                    r_expired      <= 1'b1;
                    r_one_hz       <= 1'b0;
                    r_seconds_left <= 4'd0;
                end
                ST_WAIT_START: begin
                    r_divider <= '0;
                    r_expired <= 1'b0;
                    r_one_hz  <= 1'b0;
                    if (start_timer) begin
                        r_state        <= ST_RUNNING;
                        r_count        <= w_interval_value;
                        r_seconds_left <= w_interval_value;
                    end else begin
                        r_state        <= ST_WAIT_START;
                        r_count        <= 4'd0;
                        r_seconds_left <= 4'd0;
                    end
                end
                ST_RUNNING: begin
                    r_expired <= 1'b0;
                    if (start_timer) begin
                        r_state        <= ST_RUNNING;
                        r_divider      <= '0;
                        r_count        <= w_interval_value;
                        r_one_hz       <= 1'b0;
                        r_seconds_left <= w_interval_value;
                    end else if (r_divider == DIV_MAX) begin
                        r_divider <= '0;
                        r_one_hz  <= 1'b1;
                        // Last second elapsed: expiry is reported one cycle later from EXPIRE.
                        if (r_count <= 4'd1) begin
                            r_state        <= ST_EXPIRE;
                            r_count        <= 4'd0;
                            r_seconds_left <= 4'd0;
                        end else begin
                            r_state        <= ST_RUNNING;
                            r_count        <= w_count_dec;
                            r_seconds_left <= w_count_dec;
                        end
                    end else begin
                        r_state        <= ST_RUNNING;
                        r_divider      <= r_divider + 1'b1;
                        r_one_hz       <= 1'b0;
                        r_seconds_left <= r_count;
                    end
                end
                ST_EXPIRE: begin
                    r_one_hz <= 1'b0;
                    if (start_timer) begin
                        r_state        <= ST_RUNNING;
                        r_divider      <= '0;
                        r_count        <= w_interval_value;
                        r_expired      <= 1'b0;
                        r_seconds_left <= w_interval_value;
                    end else begin
                        r_state        <= ST_WAIT_START;
                        r_divider      <= '0;
                        r_count        <= 4'd0;
                        r_expired      <= 1'b1;
                        r_seconds_left <= 4'd0;
                    end
                end
                default: begin
                    r_state        <= ST_KICK;
                    r_divider      <= '0;
                    r_count        <= 4'd0;
                    r_expired      <= 1'b0;
                    r_one_hz       <= 1'b0;
                    r_seconds_left <= 4'd0;
                end
            endcase
        end
    end

    assign expired       = r_expired;
    assign one_hz_enable = r_one_hz;
    assign seconds_left  = r_seconds_left;

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer with CLK_HZ=4; every expected value is hand-computed.
module tb_interval_timer;

    logic       clock = 1'b0;
    logic       reset_sync = 1'b1;
    logic       prog_sync = 1'b0;
    logic [1:0] time_param_sel = 2'b11;
    logic [3:0] time_value = 4'd0;
    logic [1:0] interval = 2'b00;
    logic       start_timer = 1'b0;
    logic       expired;
    logic       one_hz_enable;
    logic [3:0] seconds_left;

    int n_vec = 0;
    int n_err = 0;

    interval_timer #(.CLK_HZ(4), .DEF_BASE(6), .DEF_EXT(3), .DEF_YEL(2)) dut (
        .clock          (clock),
        .reset_sync     (reset_sync),
        .prog_sync      (prog_sync),
        .time_param_sel (time_param_sel),
        .time_value     (time_value),
        .interval       (interval),
        .start_timer    (start_timer),
        .expired        (expired),
        .one_hz_enable  (one_hz_enable),
        .seconds_left   (seconds_left)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One active edge, then settle so outputs reflect that edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Hold prog_sync for n cycles, then release and expect exactly one kick pulse.
    task automatic do_prog(input logic [1:0] sel, input logic [3:0] val, input int n,
                           input logic with_start, input string tag);
        prog_sync = 1'b1;
        time_param_sel = sel;
        time_value = val;
        start_timer = with_start;
        for (int i = 0; i < n; i++) begin
            step();
            chk({tag, "_prog_exp"}, 32'(expired), 32'd0);
            chk({tag, "_prog_sl"}, 32'(seconds_left), 32'd0);
            chk({tag, "_prog_hz"}, 32'(one_hz_enable), 32'd0);
        end
        prog_sync = 1'b0;
        start_timer = 1'b0;
        time_param_sel = 2'b11;
        time_value = 4'd0;
        step();
        chk({tag, "_kick"}, 32'(expired), 32'd1);
        step();
        chk({tag, "_kick_end"}, 32'(expired), 32'd0);
    endtask

    // Start a run and check every edge up to a few cycles past the expected expiry.
    task automatic run_timer(input logic [1:0] iv, input int secs, input int edges,
                             input string tag);
        interval = iv;
        start_timer = 1'b1;
        step();
        start_timer = 1'b0;
        chk({tag, "_sl0"}, 32'(seconds_left), 32'(secs));
        for (int i = 1; i <= edges + 6; i++) begin
            step();
            chk({tag, "_exp"}, 32'(expired), 32'(i == edges));
            chk({tag, "_hz"}, 32'(one_hz_enable), 32'((i % 4 == 0) && (i < edges)));
            if ((i % 4 == 0) && (i < edges)) begin
                chk({tag, "_sl"}, 32'(seconds_left), 32'(secs - i / 4));
            end
        end
    endtask

    initial begin
        // 1: reset then kick
        repeat (3) step();
        chk("rst_exp", 32'(expired), 32'd0);
        chk("rst_hz", 32'(one_hz_enable), 32'd0);
        chk("rst_sl", 32'(seconds_left), 32'd0);
        reset_sync = 1'b0;
        step();
        chk("rst_kick", 32'(expired), 32'd1);
        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle_exp", 32'(expired), 32'd0);
            chk("idle_hz", 32'(one_hz_enable), 32'd0);
        end

        // 2: default base run, 6 s -> 25 edges
        run_timer(2'b00, 6, 25, "base");

        // 3: programming
        do_prog(2'b01, 4'd5, 1, 1'b0, "p_ext5");
        run_timer(2'b01, 5, 21, "ext5");
        do_prog(2'b10, 4'd3, 1, 1'b0, "p_yel3");
        run_timer(2'b10, 3, 13, "yel3");
        do_prog(2'b10, 4'd0, 1, 1'b0, "p_yel0");
        run_timer(2'b10, 2, 9, "yel_def");
        do_prog(2'b11, 4'd9, 1, 1'b0, "p_none");
        run_timer(2'b00, 6, 25, "none_base");
        run_timer(2'b01, 5, 21, "none_ext");
        run_timer(2'b10, 2, 9, "none_yel");

        // 4: restart 5 cycles into a yellow run
        interval = 2'b10;
        start_timer = 1'b1;
        step();
        start_timer = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rs_pre_exp", 32'(expired), 32'd0);
        end
        run_timer(2'b00, 6, 25, "restart");

        // 5a: abort by programming mid-run (start in same cycle must lose)
        interval = 2'b00;
        start_timer = 1'b1;
        step();
        start_timer = 1'b0;
        repeat (6) step();
        chk("ab_sl_mid", 32'(seconds_left), 32'd5);
        do_prog(2'b11, 4'd9, 2, 1'b1, "abort");
        for (int i = 0; i < 10; i++) begin
            step();
            chk("ab_quiet", 32'(expired), 32'd0);
        end
        run_timer(2'b00, 6, 25, "ab_base");

        // 5b: reset mid-run restores defaults
        do_prog(2'b00, 4'd4, 1, 1'b0, "p_base4");
        do_prog(2'b01, 4'd7, 1, 1'b0, "p_ext7");
        interval = 2'b00;
        start_timer = 1'b1;
        step();
        start_timer = 1'b0;
        chk("rb_sl0", 32'(seconds_left), 32'd4);
        repeat (5) step();
        reset_sync = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rb_exp", 32'(expired), 32'd0);
            chk("rb_sl", 32'(seconds_left), 32'd0);
            chk("rb_hz", 32'(one_hz_enable), 32'd0);
        end
        reset_sync = 1'b0;
        step();
        chk("rb_kick", 32'(expired), 32'd1);
        step();
        chk("rb_kick_end", 32'(expired), 32'd0);
        run_timer(2'b00, 6, 25, "rb_base");
        run_timer(2'b01, 3, 13, "rb_ext");
        run_timer(2'b10, 2, 9, "rb_yel");

        // 6: full-scale t_base via interval code 11
        do_prog(2'b00, 4'd15, 1, 1'b0, "p_base15");
        run_timer(2'b11, 15, 61, "full");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
- Timing stage paired with the traffic-light controller FSM.
- Holds the three programmable durations: t_base, t_ext and t_yel.
- Generates a one-second enable from the system clock and counts down the duration selected by the FSM's interval code.
- Returns a one-cycle expired pulse that advances the FSM, plus a kick pulse after reset/programming so the FSM leaves S0.

Parameters:
CLK_HZ, 50000000, clock cycles per second; sets the one_hz_enable period (benches use 4)
DEF_BASE, 6, reset/default value of t_base in seconds
DEF_EXT, 3, reset/default value of t_ext in seconds
DEF_YEL, 2, reset/default value of t_yel in seconds

Ports:
clock  input  1  system clock; all logic on rising edge
reset_sync  input  1  synchronous, active-high reset (already synchronised upstream)
prog_sync  input  1  synchronised program strobe; level-sensitive
time_param_sel  input  2  00=t_base, 01=t_ext, 10=t_yel, 11=none
time_value  input  4  seconds to store, 0..15
interval  input  2  duration code from FSM; same encoding as time_param_sel; 11 treated as t_base
start_timer  input  1  one-cycle load strobe from FSM
expired  output  1  one-cycle pulse: duration elapsed, or kick
one_hz_enable  output  1  one-cycle pulse every CLK_HZ cycles while RUNNING
seconds_left  output  4  remaining whole seconds; 0 when not RUNNING

Behaviour:
- Single clock, clock. Reset is synchronous, active-high (reset_sync) and overrides everything.
- Reset values:
  - t_base=DEF_BASE, t_ext=DEF_EXT, t_yel=DEF_YEL.
  - divider=0, count=0, state=KICK.
  - expired=0, one_hz_enable=0, seconds_left=0.
- Parameter write: on every edge with prog_sync=1, the register selected by time_param_sel loads time_value.
  - time_value=0 loads that register's DEF_ value.
  - sel=11 writes nothing.
  - Writes are allowed in any state.
- States:
  - KICK: expired=0 while prog_sync=1. On the first edge with prog_sync=0, register expired=1 for one cycle, then go to WAIT_START.
  - WAIT_START: idle; divider held at 0. start_timer=1 loads count with the register selected by interval, clears the divider, and goes to RUNNING.
  - RUNNING: divider increments each cycle. When divider==CLK_HZ-1 it wraps to 0 and one_hz_enable=1 for the next cycle. On that same edge count decrements; if count was 1, go to EXPIRE.
  - EXPIRE: expired=1 for exactly one cycle, then go to WAIT_START.
- Latency: expired is high during the cycle beginning value*CLK_HZ+1 edges after the edge that sampled start_timer.
- seconds_left mirrors count in RUNNING and is 0 otherwise.
- Boundary and simultaneous-event rules:
  - start_timer while RUNNING or EXPIRE: reload count and divider, go to RUNNING, suppress any pending expired. Exactly one expired is produced per final load.
  - prog_sync=1 in any state: abort the run, clear count/divider/outputs, go to KICK. The FSM is forced to S0 concurrently, and the kick re-arms it on release.
  - start_timer and prog_sync in the same cycle: prog_sync wins.
  - reset_sync mid-run: all reset values are restored next edge. No expired until the kick after release.
- expired is never high on two consecutive cycles. one_hz_enable never pulses outside RUNNING.
- The FSM asserts start_timer one cycle after seeing expired; the block must accept start_timer in WAIT_START at any later cycle.

Test Plan:
1. Reset kick: CLK_HZ=4; hold reset_sync 3 cycles, then release with prog_sync=0 -> expired high exactly one cycle, on the first cycle after release. No further pulse for 50 cycles without start_timer.
2. Base run: start_timer pulse with interval=00 (defaults) -> one_hz_enable pulses every 4 cycles. seconds_left steps 6,5..1. expired single pulse 25 edges after the start edge.
3. Programming: prog_sync=1, sel=01, value=5, then release -> kick pulse. Next, start with interval=01 -> expired 21 edges later. Also: value=0 to sel=10 restores t_yel=2 (run gives 9 edges); sel=11 with value=9 changes no register.
4. Restart: start (interval=10, t_yel=2), then a second start_timer 5 cycles later with interval=00 -> only one expired, 25 edges after the second start.
5. Abort/reset mid-run: prog_sync=1 for 2 cycles during a t_base run -> seconds_left=0, no expired until the kick on the first prog_sync=0 cycle. Repeat with reset_sync -> same, with all registers at defaults.
6. Full-scale: program t_base=15, start with interval=11 -> uses t_base; expired after 61 edges. seconds_left starts at 15 with no wrap.
